// File: rtl/ama_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ama_pkg                                                      |
// | Description : Shared types for the approximate-mirror-adder error monitor: |
// |               AMA cell selector, monitor FSM states and the single-bit     |
// |               AMA cell function used by the adder core.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ama_pkg;

  // Cell selector. Encodings 1..5 are the five mirror-adder approximations;
  // every other encoding behaves as an exact full adder.
  typedef enum logic [2:0] {
    AMA_EXACT = 3'd0,
    AMA_M1    = 3'd1,
    AMA_M2    = 3'd2,
    AMA_M3    = 3'd3,
    AMA_M4    = 3'd4,
    AMA_M5    = 3'd5
  } ama_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One adder cell. Returns {carry_out, sum}.
  function automatic logic [1:0] ama_cell(input logic [2:0] mode,
                                          input logic a,
                                          input logic b,
                                          input logic c);
    logic maj;
    logic s;
    logic co;
    maj = (a & b) | (a & c) | (b & c);
    case (mode)
      AMA_M1:  begin s = ~maj;                     co = maj;          end
      AMA_M2:  begin s = ~maj;                     co = a | (b & c);  end
      AMA_M3:  begin s = ~a;                       co = a | (b & c);  end
      AMA_M4:  begin s = (~a & b) | (a & b & c);   co = a;            end
      AMA_M5:  begin s = b;                        co = a;            end
      default: begin s = a ^ b ^ c;                co = maj;          end
    endcase
    return {co, s};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ama_err_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ama_err_monitor_if                                           |
// | Description : Operand and result streams of the AMA error monitor.         |
// |               in_*  : valid/ready operand stream (a, b, cin)               |
// |               out_* : valid/ready result stream (s, cout, signed error)    |
// |               master = stimulus side, slave = monitor side.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface ama_err_monitor_if #(
  parameter int WIDTH = 28
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_cout;
  logic [WIDTH+1:0] out_err;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_s, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_s, out_cout, out_err
  );
endinterface
`default_nettype wire

// File: rtl/ama_adder_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ama_adder_core                                               |
// | Description : Combinational WIDTH-bit ripple adder whose low k cells use   |
// |               the APPR_MODE mirror-adder approximation, plus the exact     |
// |               sum of the same operands for error measurement.              |
// | Ports       : k           in   number of approximate LSB cells (<= WIDTH)  |
// |               a, b, cin   in   operands                                    |
// |               s, cout     out  approximate sum                             |
// |               exact_s/cout out exact sum                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ama_adder_core
  import ama_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int APPR_MODE = 4,
  parameter int KW        = $clog2(WIDTH + 1)
) (
  input  wire logic [KW-1:0]    k,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic             cin,
  output logic      [WIDTH-1:0] s,
  output logic                  cout,
  output logic      [WIDTH-1:0] exact_s,
  output logic                  exact_cout
);

  // Out-of-range mode values fall back to the exact cell.
  localparam logic [2:0] c_mode = (APPR_MODE >= 1 && APPR_MODE <= 5) ? 3'(APPR_MODE) : 3'd0;

  // The carry is walked in a procedural loop so the chain stays a single
  // combinational process rather than a bit-sliced feedback vector.
  always_comb begin
    logic       w_c;
    logic [1:0] w_cell;
    w_c    = cin;
    w_cell = '0;
    s      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k > KW'(i)) w_cell = ama_cell(c_mode, a[i], b[i], w_c);
      else            w_cell = ama_cell(AMA_EXACT, a[i], b[i], w_c);
      s[i] = w_cell[0];
      w_c  = w_cell[1];
    end
    cout = w_c;
  end

  assign {exact_cout, exact_s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/ama_err_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ama_err_monitor                                              |
// | Description : Pipelined approximate-mirror-adder datapath with on-line     |
// |               error statistics over runs of cfg_n samples.                 |
// | Ports       : clk, rst_n        clock / async active-low reset             |
// |               start             clear stats, latch cfg_n/cfg_k, run        |
// |               cfg_n, cfg_k      samples per run / approximate LSB cells    |
// |               bus (slave)       operand and result valid/ready streams     |
// |               stat_cnt          samples accumulated this run               |
// |               stat_sum          saturating signed sum of errors            |
// |               stat_sqsum        saturating sum of squared errors           |
// |               stat_maxabs       largest |error| seen                       |
// |               stat_sat          sticky accumulator-saturation flag         |
// |               busy, done        in RUN / one-cycle end-of-run pulse        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ama_err_monitor
  import ama_pkg::*;
#(
  parameter int  WIDTH     = 28,
  parameter int  APPR_MODE = 4,
  parameter int  CNT_W     = 32,
  parameter int  ACC_W     = 64,
  localparam int KW        = $clog2(WIDTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             start,
  input  wire logic [CNT_W-1:0] cfg_n,
  input  wire logic [KW-1:0]    cfg_k,
  ama_err_monitor_if.slave      bus,
  output logic      [CNT_W-1:0] stat_cnt,
  output logic      [ACC_W-1:0] stat_sum,
  output logic      [ACC_W-1:0] stat_sqsum,
  output logic      [WIDTH:0]   stat_maxabs,
  output logic                  stat_sat,
  output logic                  busy,
  output logic                  done
);

  // Accumulators are evaluated one bit wider than the larger of the
  // accumulator and the incoming term so overflow is visible before clamping.
  localparam int c_sq_w    = 2 * WIDTH + 2;
  localparam int c_sqacc_w = ((c_sq_w > ACC_W) ? c_sq_w : ACC_W) + 1;
  localparam int c_sacc_w  = (((WIDTH + 2) > ACC_W) ? (WIDTH + 2) : ACC_W) + 1;

  localparam logic [KW-1:0]               c_k_max  = KW'(WIDTH);
  localparam logic [c_sqacc_w-1:0]        c_sq_max = c_sqacc_w'({ACC_W{1'b1}});
  localparam logic signed [c_sacc_w-1:0]  c_s_max  = c_sacc_w'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [c_sacc_w-1:0]  c_s_min  = ~c_s_max;

  state_e                    r_state;
  logic [CNT_W-1:0]          r_n;
  logic [CNT_W-1:0]          r_cnt;
  logic [KW-1:0]             r_k;
  logic signed [ACC_W-1:0]   r_sum;
  logic [ACC_W-1:0]          r_sqsum;
  logic [WIDTH:0]            r_maxabs;
  logic                      r_sat;
  logic                      r_done;
  logic                      r_out_valid;
  logic [WIDTH-1:0]          r_out_s;
  logic                      r_out_cout;
  logic signed [WIDTH+1:0]   r_out_err;

  logic [WIDTH-1:0]          w_s;
  logic                      w_cout;
  logic [WIDTH-1:0]          w_es;
  logic                      w_ecout;
  logic signed [WIDTH+1:0]   w_err;
  logic signed [WIDTH+1:0]   w_neg_err;
  logic [WIDTH:0]            w_abs;
  logic [c_sq_w-1:0]         w_sq;
  logic [c_sqacc_w-1:0]      w_sq_acc;
  logic                      w_sq_sat;
  logic [ACC_W-1:0]          w_sq_next;
  logic signed [c_sacc_w-1:0] w_sum_acc;
  logic                      w_sum_hi;
  logic                      w_sum_lo;
  logic signed [ACC_W-1:0]   w_sum_next;
  logic [CNT_W-1:0]          w_cnt_inc;
  logic                      w_hs;
  logic [KW-1:0]             w_k_clamped;

  ama_adder_core #(
    .WIDTH     (WIDTH),
    .APPR_MODE (APPR_MODE),
    .KW        (KW)
  ) u_core (
    .k          (r_k),
    .a          (bus.in_a),
    .b          (bus.in_b),
    .cin        (bus.in_cin),
    .s          (w_s),
    .cout       (w_cout),
    .exact_s    (w_es),
    .exact_cout (w_ecout)
  );

  // Both sums are WIDTH+1-bit unsigned, so their difference fits WIDTH+2 signed
  // and its magnitude always fits WIDTH+1 bits.
  assign w_err     = $signed({1'b0, w_cout, w_s}) - $signed({1'b0, w_ecout, w_es});
  assign w_neg_err = -w_err;
  assign w_abs     = w_err[WIDTH+1] ? w_neg_err[WIDTH:0] : w_err[WIDTH:0];
  assign w_sq      = c_sq_w'(w_abs) * c_sq_w'(w_abs);

  assign w_sq_acc  = c_sqacc_w'(r_sqsum) + c_sqacc_w'(w_sq);
  assign w_sq_sat  = (w_sq_acc > c_sq_max);
  assign w_sq_next = w_sq_sat ? {ACC_W{1'b1}} : w_sq_acc[ACC_W-1:0];

  assign w_sum_acc  = c_sacc_w'(r_sum) + c_sacc_w'(w_err);
  assign w_sum_hi   = (w_sum_acc > c_s_max);
  assign w_sum_lo   = (w_sum_acc < c_s_min);
  assign w_sum_next = w_sum_hi ? $signed(c_s_max[ACC_W-1:0]) :
                      w_sum_lo ? $signed(c_s_min[ACC_W-1:0]) :
                                 $signed(w_sum_acc[ACC_W-1:0]);

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_k_clamped = (cfg_k > c_k_max) ? c_k_max : cfg_k;

  // Ready looks through the output register when downstream drains in the
  // same cycle, giving one sample per clock. Never ready while restarting.
  assign bus.in_ready = (r_state == RUN) && (r_cnt < r_n) &&
                        (!r_out_valid || bus.out_ready) && !start;
  assign w_hs = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_k         <= '0;
      r_sum       <= '0;
      r_sqsum     <= '0;
      r_maxabs    <= '0;
      r_sat       <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_cout  <= 1'b0;
      r_out_err   <= '0;
    end else begin
      r_done <= 1'b0;

      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      // A handshake is only possible in RUN, so it alone drives RUN->DONE.
      if (w_hs) begin
        r_out_valid <= 1'b1;
        r_out_s     <= w_s;
        r_out_cout  <= w_cout;
        r_out_err   <= w_err;
        r_cnt       <= w_cnt_inc;
        r_sum       <= w_sum_next;
        r_sqsum     <= w_sq_next;
        if (w_abs > r_maxabs) r_maxabs <= w_abs;
        if (w_sq_sat || w_sum_hi || w_sum_lo) r_sat <= 1'b1;
        if (w_cnt_inc == r_n) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
      end

      // Restart from any state; a pending result keeps draining.
      if (start) begin
        r_n      <= cfg_n;
        r_k      <= w_k_clamped;
        r_cnt    <= '0;
        r_sum    <= '0;
        r_sqsum  <= '0;
        r_maxabs <= '0;
        r_sat    <= 1'b0;
        if (cfg_n == '0) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= RUN;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_s     = r_out_s;
  assign bus.out_cout  = r_out_cout;
  assign bus.out_err   = r_out_err;
  assign stat_cnt      = r_cnt;
  assign stat_sum      = r_sum;
  assign stat_sqsum    = r_sqsum;
  assign stat_maxabs   = r_maxabs;
  assign stat_sat      = r_sat;
  assign busy          = (r_state == RUN);
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ama_err_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ama_err_monitor                                           |
// | Description : Self-checking bench for ama_err_monitor (8-bit, M5 cell,    |
// |               16-bit accumulators). A behavioural model computes the       |
// |               approximate sum arithmetically and tracks the run stats.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ama_err_monitor;
  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = 16;
  localparam int KW    = $clog2(W + 1);
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_n = '0;
  logic [KW-1:0]    cfg_k = '0;
  logic [CNT_W-1:0] stat_cnt;
  logic [ACC_W-1:0] stat_sum;
  logic [ACC_W-1:0] stat_sqsum;
  logic [W:0]       stat_maxabs;
  logic             stat_sat;
  logic             busy;
  logic             done;

  ama_err_monitor_if #(.WIDTH(W)) bus ();

  ama_err_monitor #(
    .WIDTH(W), .APPR_MODE(5), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .bus(bus), .stat_cnt(stat_cnt), .stat_sum(stat_sum), .stat_sqsum(stat_sqsum),
    .stat_maxabs(stat_maxabs), .stat_sat(stat_sat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Model state
  int     m_state, m_n, m_k, m_cnt, m_max;
  longint m_sum, m_sq;
  bit     m_sat, m_ov, m_done;
  int     m_s, m_cout, m_err;

  localparam longint c_smax  = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint c_smin  = -(longint'(1) << (ACC_W - 1));
  localparam longint c_sqmax = (longint'(1) << ACC_W) - 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    checks++;
    if ((act & m) !== (exp & m)) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act & m, exp & m);
    end
  endtask

  // M5 adder: the low k sum bits copy b, the carry into bit k is a[k-1],
  // and the upper bits are an exact addition.
  function automatic void ref_add(input int a, input int b, input int cin, input int k,
                                  output int s, output int cout, output int err);
    int lo, c, ap, ex;
    lo = (k == 0) ? 0 : (b & ((1 << k) - 1));
    c  = (k == 0) ? cin : ((a >> (k - 1)) & 1);
    ap = lo + ((((a >> k) + (b >> k) + c)) << k);
    ex = a + b + cin;
    s    = ap & ((1 << W) - 1);
    cout = (ap >> W) & 1;
    err  = ap - ex;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_n = 0; m_k = 0; m_cnt = 0; m_max = 0;
    m_sum = 0; m_sq = 0; m_sat = 0; m_ov = 0; m_done = 0;
    m_s = 0; m_cout = 0; m_err = 0;
  endtask

  function automatic bit exp_ready();
    return (m_state == S_RUN) && (m_cnt < m_n) && (!m_ov || bus.out_ready) && !start;
  endfunction

  task automatic model_update(input bit rdy);
    int s, co, e, ab;
    bit hs;
    hs = bus.in_valid && rdy;
    m_done = 0;
    if (m_ov && bus.out_ready) m_ov = 0;
    if (hs) begin
      ref_add(int'(bus.in_a), int'(bus.in_b), int'(bus.in_cin), m_k, s, co, e);
      m_ov = 1; m_s = s; m_cout = co; m_err = e;
      m_cnt++;
      m_sum += e;
      if (m_sum > c_smax) begin m_sum = c_smax; m_sat = 1; end
      if (m_sum < c_smin) begin m_sum = c_smin; m_sat = 1; end
      m_sq += longint'(e) * e;
      if (m_sq > c_sqmax) begin m_sq = c_sqmax; m_sat = 1; end
      ab = (e < 0) ? -e : e;
      if (ab > m_max) m_max = ab;
      if (m_cnt == m_n) begin m_state = S_DONE; m_done = 1; end
    end
    if (start) begin
      m_n = int'(cfg_n);
      m_k = (int'(cfg_k) > W) ? W : int'(cfg_k);
      m_cnt = 0; m_sum = 0; m_sq = 0; m_max = 0; m_sat = 0;
      m_state = (m_n == 0) ? S_DONE : S_RUN;
      m_done  = (m_n == 0);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov), 1);
    if (m_ov) begin
      chk("out_s",    64'(bus.out_s),    64'(m_s),    W);
      chk("out_cout", 64'(bus.out_cout), 64'(m_cout), 1);
      chk("out_err",  64'(bus.out_err),  64'(m_err),  W + 2);
    end
    chk("stat_cnt",    64'(stat_cnt),    64'(m_cnt), CNT_W);
    chk("stat_sum",    64'(stat_sum),    64'(m_sum), ACC_W);
    chk("stat_sqsum",  64'(stat_sqsum),  64'(m_sq),  ACC_W);
    chk("stat_maxabs", 64'(stat_maxabs), 64'(m_max), W + 1);
    chk("stat_sat",    64'(stat_sat),    64'(m_sat), 1);
    chk("busy",        64'(busy),        64'(m_state == S_RUN), 1);
    chk("done",        64'(done),        64'(m_done), 1);
    if (done === 1'b1) done_seen++;
  endtask

  // Inputs are already driven (at a falling edge); check ready, clock, check outputs.
  task automatic step();
    bit rdy;
    #1;
    rdy = exp_ready();
    chk("in_ready", 64'(bus.in_ready), 64'(rdy), 1);
    @(posedge clk);
    model_update(rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_start(input int n, input int k);
    start = 1'b1; cfg_n = CNT_W'(n); cfg_k = KW'(k);
    step();
    start = 1'b0;
  endtask

  task automatic rand_operands();
    bus.in_a   = W'($urandom);
    bus.in_b   = W'($urandom);
    bus.in_cin = 1'($urandom);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    int           k;
    logic [W-1:0] s;
    logic         co;
    int           err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h0F, 8'hF0, 1'b0,  8, 8'hF0, 1'b0, -15};
    vecs[1] = '{8'h0F, 8'hF0, 1'b1,  0, 8'h00, 1'b1,   0};
    vecs[2] = '{8'h3C, 8'h15, 1'b0,  4, 8'h55, 1'b0,   4};
    vecs[3] = '{8'h80, 8'h01, 1'b1,  8, 8'h01, 1'b1, 127};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 12, 8'h00, 1'b1,   1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1,  2, 8'hFF, 1'b1,   0};
    vecs[6] = '{8'h00, 8'h07, 1'b1,  3, 8'h07, 1'b0,  -1};
    vecs[7] = '{8'h01, 8'h00, 1'b0,  1, 8'h02, 1'b0,   1};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0, 1);
    rst_n = 1'b1;
    step();

    // Exact adder (k=0): four random samples, zero error, one done pulse
    done_seen = 0;
    do_start(4, 0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; rand_operands();
      step();
      if (bus.out_valid === 1'b1) chk("k0_err_zero", 64'(bus.out_err), 64'd0, W + 2);
    end
    bus.in_valid = 1'b0;
    chk("k0_cnt", 64'(stat_cnt), 64'd4, CNT_W);
    chk("k0_sum", 64'(stat_sum), 64'd0, ACC_W);
    chk("k0_done_pulses", 64'(done_seen), 64'd1, 32);

    // Table of hand-computed single-sample runs
    foreach (vecs[i]) begin
      do_start(1, vecs[i].k);
      bus.in_valid = 1'b1; bus.in_a = vecs[i].a; bus.in_b = vecs[i].b; bus.in_cin = vecs[i].cin;
      step();
      bus.in_valid = 1'b0;
      chk("tbl_out_s",    64'(bus.out_s),     64'(vecs[i].s),  W);
      chk("tbl_out_cout", 64'(bus.out_cout),  64'(vecs[i].co), 1);
      chk("tbl_out_err",  64'(bus.out_err),   64'(vecs[i].err), W + 2);
      chk("tbl_maxabs",   64'(stat_maxabs),   64'((vecs[i].err < 0) ? -vecs[i].err : vecs[i].err), W + 1);
      step();
    end

    // Back-pressure: one sample held while out_ready is low
    do_start(10, 8);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; rand_operands();
    step();
    for (int i = 0; i < 5; i++) begin
      rand_operands();
      step();
    end
    chk("stall_cnt", 64'(stat_cnt), 64'd1, CNT_W);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rand_operands();
      step();
    end
    bus.in_valid = 1'b0;
    chk("stall_final_cnt", 64'(stat_cnt), 64'd10, CNT_W);

    // Accumulator saturation: 300 x (0x0F, 0xF0), err = -15
    do_start(300, 8);
    bus.in_valid = 1'b1; bus.in_a = 8'h0F; bus.in_b = 8'hF0; bus.in_cin = 1'b0;
    for (int i = 0; i < 305; i++) step();
    bus.in_valid = 1'b0;
    chk("sat_sqsum",  64'(stat_sqsum),  64'hFFFF, ACC_W);
    chk("sat_flag",   64'(stat_sat),    64'd1, 1);
    chk("sat_sum",    64'(stat_sum),    64'(-4500), ACC_W);
    chk("sat_cnt",    64'(stat_cnt),    64'd300, CNT_W);
    chk("sat_maxabs", 64'(stat_maxabs), 64'd15, W + 1);

    // Asynchronous reset in the middle of a run
    do_start(20, 5);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rand_operands(); step(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0, 1);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd0, 1);
    chk("arst_cnt",       64'(stat_cnt),      64'd0, CNT_W);
    chk("arst_sum",       64'(stat_sum),      64'd0, ACC_W);
    chk("arst_sqsum",     64'(stat_sqsum),    64'd0, ACC_W);
    chk("arst_maxabs",    64'(stat_maxabs),   64'd0, W + 1);
    chk("arst_busy",      64'(busy),          64'd0, 1);
    chk("arst_out_s",     64'(bus.out_s),     64'd0, W);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1; bus.in_valid = 1'b0;
    step();
    do_start(3, 8);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_operands(); step(); end
    bus.in_valid = 1'b0;
    chk("post_rst_cnt", 64'(stat_cnt), 64'd3, CNT_W);

    // Restart mid-run with cfg_n = 0
    do_start(20, 4);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_operands(); step(); end
    done_seen = 0;
    do_start(0, 4);
    for (int i = 0; i < 5; i++) begin rand_operands(); step(); end
    bus.in_valid = 1'b0;
    chk("n0_cnt", 64'(stat_cnt), 64'd0, CNT_W);
    chk("n0_sum", 64'(stat_sum), 64'd0, ACC_W);
    chk("n0_done_pulses", 64'(done_seen), 64'd1, 32);

    // Randomised runs against the model
    for (int r = 0; r < 8; r++) begin
      int n, k;
      n = $urandom_range(1, 30);
      k = $urandom_range(0, 15);
      done_seen = 0;
      do_start(n, k);
      for (int c = 0; c < 3 * n + 10; c++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        rand_operands();
        step();
      end
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      for (int c = 0; c < n + 3; c++) begin rand_operands(); step(); end
      bus.in_valid = 1'b0;
      step();
      chk("rand_run_cnt", 64'(stat_cnt), 64'(n), CNT_W);
      chk("rand_done_pulses", 64'(done_seen), 64'd1, 32);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
